// File: rtl/accum_sched.sv
// Accumulator load scheduler: round-robin grants two requesters into batches of BATCH loads.
// Optional overflow rejection is enabled by defining the macro ACC_OVF_EN.
module accum_sched #(
  parameter int BATCH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic [7:0] i_d0,
  input  logic [7:0] i_d1,
  input  logic       i_clr_req,
  input  logic [7:0] i_q,
  output logic [1:0] o_ack,
  output logic       o_err,
  output logic       o_ld,
  output logic       o_clr,
  output logic [7:0] o_d,
  output logic       o_done,
  output logic       o_ovf,
  output logic [3:0] o_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [1:0] CLEAR = 2'd3;

  localparam logic [3:0] BATCH_C = 4'(BATCH);

  logic [1:0] r_state;
  logic [1:0] r_ack;
  logic       r_err;
  logic       r_ld;
  logic       r_clr;
  logic [7:0] r_d;
  logic       r_done;
  logic       r_ovf;
  logic [3:0] r_cnt;
  logic       r_last;
  logic       r_clr_pend;

  logic [1:0] w_gnt;
  logic [7:0] w_opnd;
  logic       w_ovf;

  // Round-robin: on a double request the requester not granted last wins.
  always_comb begin
    w_gnt = 2'b00;
    case (i_req)
      2'b11:   w_gnt = r_last ? 2'b01 : 2'b10;
      2'b10:   w_gnt = 2'b10;
      2'b01:   w_gnt = 2'b01;
      default: w_gnt = 2'b00;
    endcase
  end

  assign w_opnd = w_gnt[1] ? i_d1 : i_d0;

`ifdef ACC_OVF_EN
  logic [8:0] w_sum;
  assign w_sum = {1'b0, i_q} + {1'b0, w_opnd};
  assign w_ovf = w_sum[8];
`else
  // Q is not looked at in this build; the reduction only keeps the port referenced.
  assign w_ovf = 1'b0 & (^i_q);
`endif

  // Control FSM; every output is a register, strobes default low each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ack      <= 2'b00;
      r_err      <= 1'b0;
      r_ld       <= 1'b0;
      r_clr      <= 1'b0;
      r_d        <= 8'h00;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_cnt      <= 4'd0;
      r_last     <= 1'b1;
      r_clr_pend <= 1'b0;
    end else begin
      r_ack  <= 2'b00;
      r_err  <= 1'b0;
      r_ld   <= 1'b0;
      r_clr  <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_clr_req || r_clr_pend) begin
            r_state    <= CLEAR;
            r_clr      <= 1'b1;
            r_cnt      <= 4'd0;
            r_ovf      <= 1'b0;
            r_clr_pend <= 1'b0;
          end else if (i_req != 2'b00) begin
            r_state <= LOAD;
            r_ack   <= w_gnt;
            r_d     <= w_opnd;
            if (w_ovf) begin
              r_err <= 1'b1;
              r_ovf <= 1'b1;
            end else begin
              r_ld  <= 1'b1;
              r_cnt <= r_cnt + 4'd1;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        LOAD: begin
          r_last <= r_ack[1];
          if (i_clr_req) begin
            r_clr_pend <= 1'b1;
          end else begin
            r_clr_pend <= r_clr_pend;
          end
          // r_cnt already holds the incremented count during LOAD.
          if (!r_err && (r_cnt == BATCH_C)) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        DONE: begin
          r_state    <= CLEAR;
          r_clr      <= 1'b1;
          r_cnt      <= 4'd0;
          r_ovf      <= 1'b0;
          r_clr_pend <= 1'b0;
        end
        CLEAR: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_ack  = r_ack;
  assign o_err  = r_err;
  assign o_ld   = r_ld;
  assign o_clr  = r_clr;
  assign o_d    = r_d;
  assign o_done = r_done;
  assign o_ovf  = r_ovf;
  assign o_cnt  = r_cnt;

endmodule
